// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART program loader.
// State encodings, UART frame shape and default bit timing live here.
package boot_loader_pkg;

  typedef enum logic [1:0] {
    WAIT_LEN = 2'd0,
    LOAD     = 2'd1,
    DONE     = 2'd2
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_ADDR_W       = 8;
  localparam int TIMER_W          = 16;

  // A length byte of zero encodes a full 256-byte image.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Instruction memory write port driven by the loader.
// Latency: n/a; backpressure: none, memory must accept one write per strobe.
interface boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              imem_w_en;
  logic [ADDR_W-1:0] imem_w_addr;
  logic [7:0]        imem_w_data;

  modport master (output imem_w_en, output imem_w_addr, output imem_w_data);
  modport slave  (input  imem_w_en, input  imem_w_addr, input  imem_w_data);
endinterface

// File: rtl/boot_loader_uart_rx.sv
// 8N1 UART receiver: sync, mid-bit sampling, 1-cycle rx_valid or rx_ferr pulse.
// Latency: pulse 3 cycles after the stop-bit midpoint reaches rx; backpressure: none.
module boot_loader_uart_rx
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam logic [TIMER_W-1:0] FULL_M1  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_M1  = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]         LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta, rx_sync, rx_prev;
  rx_state_t            state_q, state_d;
  logic [TIMER_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Start bit must still be low at its midpoint, otherwise it was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_sync, sh_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_d = RX_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_sync;
          ferr_d  = !rx_sync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_data  = sh_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/boot_loader.sv
// UART program loader: length byte then image bytes into imem, then releases the CPU.
// Latency: write strobe 1 cycle after rx_valid; backpressure: none, bytes arrive at line rate.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx,
  input  logic          reload,
  boot_loader_if.master imem,
  output logic          cpu_run,
  output logic          busy,
  output logic          frame_err
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  boot_loader_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic              wen_q, wen_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              ferr_q, ferr_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_LEN;
      addr_q  <= '0;
      rem_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    // The address shown on the port is the one being written; it advances after the strobe.
    if (wen_q) addr_d = addr_q + 1'b1;
    case (state_q)
      WAIT_LEN: begin
        if (rx_valid) begin
          rem_d   = len_to_count(rx_data);
          addr_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (rx_valid) begin
          wen_d   = 1'b1;
          wdata_d = rx_data;
          rem_d   = rem_q - 1'b1;
          if (rem_q == 9'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (reload) state_d = WAIT_LEN;
      end
      default: state_d = WAIT_LEN;
    endcase
    // cpu_run lags DONE by one cycle so it never overlaps the final strobe.
    run_d  = (state_q == DONE) && !reload;
    busy_d = (state_d == LOAD) || wen_d;
    ferr_d = ferr_q || rx_ferr;
  end

  assign imem.imem_w_en   = wen_q;
  assign imem.imem_w_addr = addr_q;
  assign imem.imem_w_data = wdata_q;
  assign cpu_run          = run_q;
  assign busy             = busy_q;
  assign frame_err        = ferr_q;

endmodule
